ddr3_burst_engine: RTL and testbench

- Parametrised transfer engine between user streams and one DDR3 MCB port (command, write-data and read-data FIFOs).
- Accepts a start address and a word count, splits the transfer into bursts, and issues the bursts as MCB commands.
- Bursts never exceed MAX_BURST and never cross a BOUNDARY_WORDS-aligned boundary.
- Supports abort and sticky error reporting; sits between the Wishbone/DMA front end and the MCB wrapper.

---
 rtl/ddr3_burst_engine.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_ddr3_burst_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_burst_engine.sv
// ---------------------------------------------------------------------------
// ddr3_burst_engine
//
// Moves a block of words between a user stream and one DDR3 MCB port.
// A transfer (start address + word count) is split into bursts of at most
// MAX_BURST words.  No burst crosses a BOUNDARY_WORDS-aligned boundary.
// Each burst is issued as one MCB command.  Writes fill the MCB write-data
// FIFO first and then issue the command.  Reads issue the command first and
// then forward the returned words.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               one-cycle request, sampled only while idle
//   i_dir                 0 = write to DDR3, 1 = read from DDR3
//   i_start_addr          first word address of the transfer
//   i_xfer_len            number of words to move (0 completes at once)
//   i_abort               level; stops the transfer early
//   o_busy                high whenever the engine is not idle
//   o_done                one-cycle pulse when a transfer ends
//   o_aborted             sticky: the last transfer was aborted
//   o_error               sticky: an MCB FIFO error was seen; cleared on start
//   o_words_done          words moved to or from the user streams
//   i_wr_s_*/o_wr_s_ready write stream (valid/ready)
//   o_rd_m_*/i_rd_m_ready read stream (valid/ready)
//   o_cmd_*, i_cmd_full   MCB command FIFO
//   o_wr_*, i_wr_*        MCB write-data FIFO
//   o_rd_en, i_rd_*       MCB read-data FIFO
// ---------------------------------------------------------------------------
module ddr3_burst_engine #(
    parameter int ADDR_WIDTH     = 28,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 24,
    parameter int MAX_BURST      = 64,
    parameter int BOUNDARY_WORDS = 256
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    // Transfer control
    input  logic                          i_start,
    input  logic                          i_dir,
    input  logic [ADDR_WIDTH-1:0]         i_start_addr,
    input  logic [LEN_WIDTH-1:0]          i_xfer_len,
    input  logic                          i_abort,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_aborted,
    output logic                          o_error,
    output logic [LEN_WIDTH-1:0]          o_words_done,
    // User write stream
    input  logic                          i_wr_s_valid,
    output logic                          o_wr_s_ready,
    input  logic [DATA_WIDTH-1:0]         i_wr_s_data,
    // User read stream
    output logic                          o_rd_m_valid,
    input  logic                          i_rd_m_ready,
    output logic [DATA_WIDTH-1:0]         o_rd_m_data,
    // MCB command FIFO
    output logic                          o_cmd_en,
    output logic [2:0]                    o_cmd_instr,
    output logic [$clog2(MAX_BURST)-1:0]  o_cmd_bl,
    output logic [ADDR_WIDTH-1:0]         o_cmd_word_addr,
    input  logic                          i_cmd_full,
    // MCB write-data FIFO
    output logic                          o_wr_en,
    output logic [DATA_WIDTH/8-1:0]       o_wr_mask,
    output logic [DATA_WIDTH-1:0]         o_wr_data,
    input  logic                          i_wr_empty,
    input  logic                          i_wr_underrun,
    input  logic                          i_wr_error,
    // MCB read-data FIFO
    output logic                          o_rd_en,
    input  logic [DATA_WIDTH-1:0]         i_rd_data,
    input  logic                          i_rd_empty,
    input  logic                          i_rd_overflow,
    input  logic                          i_rd_error
);

    localparam int BL_W  = $clog2(MAX_BURST);
    localparam int BND_W = $clog2(BOUNDARY_WORDS);

    // Burst counters hold 0..MAX_BURST, so they need one bit more than cmd_bl.
    typedef logic [BL_W:0]   cnt_t;
    typedef logic [BL_W-1:0] bl_t;

    localparam logic [2:0] INSTR_WR = 3'b010;  // write with auto precharge
    localparam logic [2:0] INSTR_RD = 3'b011;  // read with auto precharge

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_PLAN     = 4'd1;
    localparam logic [3:0] S_WR_WAIT  = 4'd2;
    localparam logic [3:0] S_WR_FILL  = 4'd3;
    localparam logic [3:0] S_WR_CMD   = 4'd4;
    localparam logic [3:0] S_RD_CMD   = 4'd5;
    localparam logic [3:0] S_RD_DATA  = 4'd6;
    localparam logic [3:0] S_RD_DRAIN = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    logic [3:0]            r_state;
    logic [3:0]            w_state_nxt;
    logic                  r_dir;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    cnt_t                  r_blen;
    cnt_t                  r_bcnt;
    logic [LEN_WIDTH-1:0]  r_words_done;
    logic                  r_aborted;
    logic                  r_error;

    logic                  w_busy;
    logic                  w_err_in;
    logic [LEN_WIDTH-1:0]  w_to_bound;
    logic [LEN_WIDTH-1:0]  w_cap;
    cnt_t                  w_blen;
    logic                  w_bcnt_full;

    assign w_busy      = (r_state != S_IDLE);
    assign w_err_in    = i_wr_underrun | i_wr_error | i_rd_overflow | i_rd_error;
    assign w_bcnt_full = (r_bcnt == r_blen);

    // Burst length: min(remaining, MAX_BURST, words left before the boundary).
    assign w_to_bound = LEN_WIDTH'(BOUNDARY_WORDS) - LEN_WIDTH'(r_addr[BND_W-1:0]);
    assign w_cap      = (w_to_bound < LEN_WIDTH'(MAX_BURST)) ? w_to_bound
                                                             : LEN_WIDTH'(MAX_BURST);
    assign w_blen     = (r_remaining < w_cap) ? cnt_t'(r_remaining) : cnt_t'(w_cap);

    assign o_busy       = w_busy;
    assign o_done       = (r_state == S_DONE);
    assign o_aborted    = r_aborted;
    assign o_error      = r_error;
    assign o_words_done = r_words_done;
    assign o_wr_mask    = '0;
    assign o_wr_data    = i_wr_s_data;
    assign o_rd_m_data  = i_rd_data;

    // Next state and all MCB/stream strobes.  The strobes are decoded from the
    // current state so they can never fire in IDLE, PLAN or DONE.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_state_nxt     = r_state;
        o_wr_s_ready    = 1'b0;
        o_wr_en         = 1'b0;
        o_rd_m_valid    = 1'b0;
        o_rd_en         = 1'b0;
        o_cmd_en        = 1'b0;
        o_cmd_instr     = '0;
        o_cmd_bl        = '0;
        o_cmd_word_addr = '0;

        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_PLAN;
            end

            S_PLAN: begin
                if (w_err_in || i_abort || (r_remaining == '0))
                    w_state_nxt = S_DONE;
                else
                    w_state_nxt = r_dir ? S_RD_CMD : S_WR_WAIT;
            end

            // An empty write FIFO is the guarantee that a whole burst fits.
            S_WR_WAIT: begin
                if (w_err_in || i_abort) w_state_nxt = S_DONE;
                else if (i_wr_empty)     w_state_nxt = S_WR_FILL;
            end

            S_WR_FILL: begin
                // Abort and error stop acceptance in the cycle they appear.
                o_wr_s_ready = (r_bcnt < r_blen) && !i_abort && !w_err_in;
                o_wr_en      = i_wr_s_valid && o_wr_s_ready;
                if (w_err_in)
                    w_state_nxt = S_DONE;
                else if (i_abort)
                    // Words already in the MCB FIFO still get a command.
                    w_state_nxt = (r_bcnt != '0) ? S_WR_CMD : S_DONE;
                else if (w_bcnt_full)
                    w_state_nxt = S_WR_CMD;
            end

            // Uses bcnt, not blen, so an aborted fill writes only what it took.
            S_WR_CMD: begin
                o_cmd_instr     = INSTR_WR;
                o_cmd_bl        = r_bcnt[BL_W-1:0] - bl_t'(1);
                o_cmd_word_addr = r_addr;
                o_cmd_en        = !i_cmd_full && !w_err_in;
                if (w_err_in)
                    w_state_nxt = S_DONE;
                else if (!i_cmd_full)
                    w_state_nxt = ((r_remaining == LEN_WIDTH'(r_bcnt)) || r_aborted || i_abort)
                                  ? S_DONE : S_PLAN;
            end

            S_RD_CMD: begin
                o_cmd_instr     = INSTR_RD;
                o_cmd_bl        = r_blen[BL_W-1:0] - bl_t'(1);
                o_cmd_word_addr = r_addr;
                o_cmd_en        = !i_cmd_full && !w_err_in && !i_abort;
                if (w_err_in || i_abort) w_state_nxt = S_DONE;
                else if (!i_cmd_full)    w_state_nxt = S_RD_DATA;
            end

            S_RD_DATA: begin
                o_rd_m_valid = !i_rd_empty && (r_bcnt < r_blen) && !i_abort && !w_err_in;
                o_rd_en      = o_rd_m_valid && i_rd_m_ready;
                if (w_err_in || i_abort)
                    w_state_nxt = S_RD_DRAIN;
                else if (w_bcnt_full)
                    w_state_nxt = (r_remaining == LEN_WIDTH'(r_blen)) ? S_DONE : S_PLAN;
            end

            // The command already asked for blen words; they must be pulled out
            // of the MCB FIFO so the next transfer starts clean.
            S_RD_DRAIN: begin
                o_rd_en = !i_rd_empty && (r_bcnt < r_blen);
                if (w_bcnt_full) w_state_nxt = S_DONE;
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every flop sees
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_dir        <= 1'b0;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_blen       <= '0;
            r_bcnt       <= '0;
            r_words_done <= '0;
            r_aborted    <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_busy && w_err_in)
                r_error <= 1'b1;
            if (w_busy && i_abort && (r_state != S_DONE))
                r_aborted <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dir        <= i_dir;
                        r_addr       <= i_start_addr;
                        r_remaining  <= i_xfer_len;
                        r_words_done <= '0;
                        r_aborted    <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end

                S_PLAN: begin
                    r_blen <= w_blen;
                    r_bcnt <= '0;
                end

                S_WR_FILL: begin
                    if (o_wr_en) begin
                        r_bcnt       <= r_bcnt + cnt_t'(1);
                        r_words_done <= r_words_done + LEN_WIDTH'(1);
                    end
                end

                S_WR_CMD: begin
                    if (o_cmd_en) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(r_bcnt);
                        r_remaining <= r_remaining - LEN_WIDTH'(r_bcnt);
                    end
                end

                S_RD_DATA: begin
                    if (o_rd_en) begin
                        r_bcnt       <= r_bcnt + cnt_t'(1);
                        r_words_done <= r_words_done + LEN_WIDTH'(1);
                    end else if (w_bcnt_full && !w_err_in && !i_abort) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(r_blen);
                        r_remaining <= r_remaining - LEN_WIDTH'(r_blen);
                    end
                end

                // Discarded words advance the burst count only.
                S_RD_DRAIN: begin
                    if (o_rd_en) r_bcnt <= r_bcnt + cnt_t'(1);
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_burst_engine.sv
// ---------------------------------------------------------------------------
// tb_ddr3_burst_engine
//
// Directed bench for ddr3_burst_engine.  Each test pushes the commands and
// data words it expects into queues; a monitor on the falling edge pops and
// compares whenever the DUT strobes cmd_en, wr_en or a read handshake.
// ---------------------------------------------------------------------------
module tb_ddr3_burst_engine;

    localparam int AW  = 28;
    localparam int DW  = 32;
    localparam int LW  = 24;
    localparam int BLW = 6;

    localparam logic [31:0] WR_BASE = 32'hD000_0000;
    localparam logic [31:0] RD_BASE = 32'hA500_0000;

    typedef logic [3+BLW+AW-1:0] cmd_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, dir, abort;
    logic [AW-1:0]   start_addr;
    logic [LW-1:0]   xfer_len;
    logic            busy, done, aborted, error;
    logic [LW-1:0]   words_done;
    logic            wr_s_valid, wr_s_ready;
    logic [DW-1:0]   wr_s_data;
    logic            rd_m_valid, rd_m_ready;
    logic [DW-1:0]   rd_m_data;
    logic            cmd_en;
    logic [2:0]      cmd_instr;
    logic [BLW-1:0]  cmd_bl;
    logic [AW-1:0]   cmd_word_addr;
    logic            cmd_full;
    logic            wr_en;
    logic [DW/8-1:0] wr_mask;
    logic [DW-1:0]   wr_data;
    logic            wr_empty, wr_underrun, wr_error;
    logic            rd_en;
    logic [DW-1:0]   rd_data;
    logic            rd_empty, rd_overflow, rd_error;

    always #5 clk = ~clk;

    ddr3_burst_engine dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_dir           (dir),
        .i_start_addr    (start_addr),
        .i_xfer_len      (xfer_len),
        .i_abort         (abort),
        .o_busy          (busy),
        .o_done          (done),
        .o_aborted       (aborted),
        .o_error         (error),
        .o_words_done    (words_done),
        .i_wr_s_valid    (wr_s_valid),
        .o_wr_s_ready    (wr_s_ready),
        .i_wr_s_data     (wr_s_data),
        .o_rd_m_valid    (rd_m_valid),
        .i_rd_m_ready    (rd_m_ready),
        .o_rd_m_data     (rd_m_data),
        .o_cmd_en        (cmd_en),
        .o_cmd_instr     (cmd_instr),
        .o_cmd_bl        (cmd_bl),
        .o_cmd_word_addr (cmd_word_addr),
        .i_cmd_full      (cmd_full),
        .o_wr_en         (wr_en),
        .o_wr_mask       (wr_mask),
        .o_wr_data       (wr_data),
        .i_wr_empty      (wr_empty),
        .i_wr_underrun   (wr_underrun),
        .i_wr_error      (wr_error),
        .o_rd_en         (rd_en),
        .i_rd_data       (rd_data),
        .i_rd_empty      (rd_empty),
        .i_rd_overflow   (rd_overflow),
        .i_rd_error      (rd_error)
    );

    // Read-data FIFO model: an endless sequence RD_BASE + n, popped by rd_en.
    logic [31:0] rd_ptr = '0;
    assign rd_data = RD_BASE + rd_ptr;
    always @(posedge clk) if (rd_en) rd_ptr <= rd_ptr + 1;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int total = 0;
    int bad   = 0;
    int n_done = 0, n_cmd = 0, n_wr = 0, n_rd = 0, n_drain = 0;
    int wr_idx = 0;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_wr[$];
    logic [31:0] exp_rd[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk_cmd(input logic [2:0] instr, input logic [BLW-1:0] bl,
                                    input logic [AW-1:0] addr);
        return {instr, bl, addr};
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cmd_en) begin
                if (exp_cmd.size() == 0) check("cmd_unexpected", 64'(exp_cmd.size()), 1);
                else check("cmd", {cmd_instr, cmd_bl, cmd_word_addr}, exp_cmd.pop_front());
                n_cmd++;
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 64'(exp_wr.size()), 1);
                else check("wr_data", wr_data, exp_wr.pop_front());
                n_wr++;
            end
            if (rd_m_valid && rd_m_ready) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 64'(exp_rd.size()), 1);
                else check("rd_data", rd_m_data, exp_rd.pop_front());
                n_rd++;
            end
            if (rd_en && !rd_m_valid) n_drain++;
            if (done) n_done++;
            if (!busy && (cmd_en || wr_en || rd_en))
                check("idle_strobe", {cmd_en, wr_en, rd_en}, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic d, input logic [AW-1:0] a, input logic [LW-1:0] n);
        start = 1'b1; dir = d; start_addr = a; xfer_len = n;
        tick();
        start = 1'b0;
    endtask

    // Offers n consecutive stream words and returns once all were accepted.
    task automatic stream_wr(input int n);
        int got = 0;
        int c = 0;
        for (int i = 0; i < n; i++) exp_wr.push_back(WR_BASE + 32'(wr_idx + i));
        while (got < n && c < 2000) begin
            wr_s_valid = 1'b1;
            wr_s_data  = WR_BASE + 32'(wr_idx);
            @(negedge clk);
            if (wr_s_ready) begin got++; wr_idx++; end
            tick();
            c++;
        end
        wr_s_valid = 1'b0;
        if (got < n) check("wr_stream_timeout", 64'(got), 64'(n));
    endtask

    task automatic wait_reads(input int n);
        int got = 0;
        int c = 0;
        while (got < n && c < 500) begin
            @(negedge clk);
            if (rd_m_valid && rd_m_ready) got++;
            tick();
            c++;
        end
        if (got < n) check("rd_wait_timeout", 64'(got), 64'(n));
    endtask

    task automatic wait_idle(input int limit);
        int c = 0;
        while (busy && c < limit) begin tick(); c++; end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic push_reads(input int n);
        for (int i = 0; i < n; i++) exp_rd.push_back(RD_BASE + rd_ptr + 32'(i));
    endtask

    int d_done, d_cmd, d_wr, d_rd, d_drain;
    task automatic snap();
        d_done = n_done; d_cmd = n_cmd; d_wr = n_wr; d_rd = n_rd; d_drain = n_drain;
    endtask

    initial begin
        int t0;
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; start_addr = '0; xfer_len = '0;
        abort = 1'b0; wr_s_valid = 1'b0; wr_s_data = '0; rd_m_ready = 1'b0;
        cmd_full = 1'b0; wr_empty = 1'b1; wr_underrun = 1'b0; wr_error = 1'b0;
        rd_empty = 1'b0; rd_overflow = 1'b0; rd_error = 1'b0;

        #1;
        check("rst_status", {busy, done, aborted, error}, 0);
        check("rst_words",  words_done, 0);
        check("rst_cmd",    {cmd_en, cmd_instr, cmd_bl, cmd_word_addr}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Write 100 words at 0x10: bursts of 64 then 36.
        snap();
        exp_cmd.push_back(mk_cmd(3'b010, 6'd63, 28'h10));
        exp_cmd.push_back(mk_cmd(3'b010, 6'd35, 28'h50));
        do_start(1'b0, 28'h10, 24'd100);
        stream_wr(100);
        wait_idle(500);
        check("wr100_done_cnt", 64'(n_done - d_done), 1);
        check("wr100_cmd_cnt",  64'(n_cmd - d_cmd), 2);
        check("wr100_wr_cnt",   64'(n_wr - d_wr), 100);
        check("wr100_words",    words_done, 100);

        // Read 40 words at 0xF0: split at the 256 boundary, ready toggling,
        // command FIFO full for the first cycles.
        snap();
        exp_cmd.push_back(mk_cmd(3'b011, 6'd15, 28'hF0));
        exp_cmd.push_back(mk_cmd(3'b011, 6'd23, 28'h100));
        push_reads(40);
        do_start(1'b1, 28'hF0, 24'd40);
        for (int c = 0; c < 1000 && busy; c++) begin
            rd_m_ready = c[0];
            cmd_full   = (c < 4);
            tick();
        end
        rd_m_ready = 1'b0; cmd_full = 1'b0;
        if (busy) check("rd40_timeout", busy, 0);
        check("rd40_done_cnt", 64'(n_done - d_done), 1);
        check("rd40_cmd_cnt",  64'(n_cmd - d_cmd), 2);
        check("rd40_rd_cnt",   64'(n_rd - d_rd), 40);
        check("rd40_words",    words_done, 40);
        check("rd40_flags",    {aborted, error}, 0);

        // Write aborted after 10 streamed words: one command for 10 words.
        snap();
        exp_cmd.push_back(mk_cmd(3'b010, 6'd9, 28'h200));
        t0 = cyc_cnt;
        do_start(1'b0, 28'h200, 24'd50);
        stream_wr(10);
        while (cyc_cnt - t0 < 20) tick();
        abort = 1'b1;
        wait_idle(100);
        abort = 1'b0;
        check("wabort_aborted",  aborted, 1);
        check("wabort_done_cnt", 64'(n_done - d_done), 1);
        check("wabort_cmd_cnt",  64'(n_cmd - d_cmd), 1);
        check("wabort_words",    words_done, 10);

        // Read 64, abort after 5 delivered: remaining 59 drained silently.
        snap();
        exp_cmd.push_back(mk_cmd(3'b011, 6'd63, 28'h400));
        push_reads(5);
        do_start(1'b1, 28'h400, 24'd64);
        rd_m_ready = 1'b1;
        wait_reads(5);
        abort = 1'b1;
        wait_idle(300);
        abort = 1'b0; rd_m_ready = 1'b0;
        check("rabort_words",    words_done, 5);
        check("rabort_drain",    64'(n_drain - d_drain), 59);
        check("rabort_aborted",  aborted, 1);
        check("rabort_done_cnt", 64'(n_done - d_done), 1);

        // Zero length: done two cycles after start, aborted cleared by start.
        snap();
        do_start(1'b0, 28'h123, 24'd0);
        check("zero_not_done_yet", done, 0);
        tick();
        check("zero_done",    done, 1);
        check("zero_aborted", aborted, 0);
        tick();
        check("zero_idle",    {busy, done}, 0);
        check("zero_cmd_cnt", 64'(n_cmd - d_cmd), 0);

        // Start pulse while busy with a read is ignored.
        snap();
        exp_cmd.push_back(mk_cmd(3'b011, 6'd7, 28'h40));
        push_reads(8);
        do_start(1'b1, 28'h40, 24'd8);
        tick();
        do_start(1'b0, 28'h99, 24'd5);
        rd_m_ready = 1'b1;
        wait_idle(100);
        rd_m_ready = 1'b0;
        tick();
        check("busy_start_words",    words_done, 8);
        check("busy_start_done_cnt", 64'(n_done - d_done), 1);
        check("busy_start_idle",     busy, 0);

        // rd_overflow mid-read: error set, rest of the burst drained.
        snap();
        exp_cmd.push_back(mk_cmd(3'b011, 6'd31, 28'h300));
        push_reads(4);
        do_start(1'b1, 28'h300, 24'd32);
        rd_m_ready = 1'b1;
        wait_reads(4);
        rd_overflow = 1'b1;
        tick();
        rd_overflow = 1'b0;
        wait_idle(200);
        rd_m_ready = 1'b0;
        check("ovf_error",    error, 1);
        check("ovf_aborted",  aborted, 0);
        check("ovf_words",    words_done, 4);
        check("ovf_drain",    64'(n_drain - d_drain), 28);
        check("ovf_done_cnt", 64'(n_done - d_done), 1);
        do_start(1'b0, 28'h0, 24'd0);
        check("err_cleared_by_start", error, 0);
        wait_idle(20);

        // Reset in the middle of a write fill: immediate idle, no done pulse.
        snap();
        do_start(1'b0, 28'h10, 24'd20);
        stream_wr(6);
        check("rst_mid_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy",  {busy, cmd_en, wr_s_ready}, 0);
        check("rst_mid_words", words_done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        check("rst_mid_no_done", 64'(n_done - d_done), 0);
        check("rst_mid_idle",    busy, 0);

        check("cmd_q_empty", 64'(exp_cmd.size()), 0);
        check("wr_q_empty",  64'(exp_wr.size()), 0);
        check("rd_q_empty",  64'(exp_rd.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
